// File: rtl/variable_logical_rightshift_pipe_pkg.sv
// Shared constants and payload view for the pipelined logical right shifter.
// The sticky build option is selected by VARIABLE_LOGICAL_RIGHTSHIFT_STICKY_EN.
package vlrs_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int SHW_DEF   = $clog2(WIDTH_DEF);

  // One pipeline slot at the default width: value, carried shift amount, sticky.
  typedef struct packed {
    logic [WIDTH_DEF-1:0] data;
    logic [SHW_DEF-1:0]   shift;
    logic                 sticky;
  } payload_t;

endpackage

// File: rtl/variable_logical_rightshift_pipe_rshift_stage.sv
// One shifter stage: conditional right shift by 2^K, registered with the pipe advance enable.
// Sticky accumulation exists only when VARIABLE_LOGICAL_RIGHTSHIFT_STICKY_EN is defined.
module rshift_stage
  import vlrs_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SHW   = $clog2(WIDTH),
  parameter int K     = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adv,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shift,
`ifdef VARIABLE_LOGICAL_RIGHTSHIFT_STICKY_EN
  input  logic             in_sticky,
  output logic             out_sticky,
`endif
  output logic             out_vld,
  output logic [WIDTH-1:0] out_data,
  output logic [SHW-1:0]   out_shift
);

  localparam int AMT = 1 << K;

  logic [WIDTH-1:0] shifted_p0;

  assign shifted_p0 = in_shift[K] ? (in_data >> AMT) : in_data;

  // Only the valid bit is reset; payload registers just follow the enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_vld <= 1'b0;
    end else if (adv) begin
      out_vld <= in_vld;
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      out_data  <= shifted_p0;
      out_shift <= in_shift;
    end
  end

`ifdef VARIABLE_LOGICAL_RIGHTSHIFT_STICKY_EN
  function automatic logic dropped_bits(input logic [WIDTH-1:0] d);
    return |(d & ~({WIDTH{1'b1}} << AMT));
  endfunction

  always_ff @(posedge clk) begin
    if (adv) begin
      out_sticky <= in_sticky | (in_shift[K] & dropped_bits(in_data));
    end
  end
`endif

endmodule

// File: rtl/variable_logical_rightshift_pipe.sv
// Pipelined variable logical right shifter, log2(WIDTH) stages, valid/ready on both sides.
// Define VARIABLE_LOGICAL_RIGHTSHIFT_STICKY_EN to add sticky_o (OR of all bits shifted out).
module variable_logical_rightshift_pipe
  import vlrs_pkg::*;
#(
  parameter  int WIDTH = WIDTH_DEF,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] val_i,
  input  logic [SHW-1:0]   shift_n_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
`ifdef VARIABLE_LOGICAL_RIGHTSHIFT_STICKY_EN
  output logic             sticky_o,
`endif
  output logic [WIDTH-1:0] result_o
);

  logic             adv;
  logic             vld_p    [0:SHW];
  logic [WIDTH-1:0] data_p   [0:SHW];
  logic [SHW-1:0]   shift_p  [0:SHW];
`ifdef VARIABLE_LOGICAL_RIGHTSHIFT_STICKY_EN
  logic             sticky_p [0:SHW];
`endif

  // The whole pipe moves in lockstep; bubbles advance like valid slots.
  assign adv        = !out_valid_o || out_ready_i;
  assign in_ready_o = adv;

  assign vld_p[0]   = in_valid_i;
  assign data_p[0]  = val_i;
  assign shift_p[0] = shift_n_i;
`ifdef VARIABLE_LOGICAL_RIGHTSHIFT_STICKY_EN
  assign sticky_p[0] = 1'b0;
`endif

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    rshift_stage #(
      .WIDTH (WIDTH),
      .SHW   (SHW),
      .K     (k)
    ) u_stage (
      .clk        (clk_i),
      .rst        (rst_i),
      .adv        (adv),
      .in_vld     (vld_p[k]),
      .in_data    (data_p[k]),
      .in_shift   (shift_p[k]),
`ifdef VARIABLE_LOGICAL_RIGHTSHIFT_STICKY_EN
      .in_sticky  (sticky_p[k]),
      .out_sticky (sticky_p[k+1]),
`endif
      .out_vld    (vld_p[k+1]),
      .out_data   (data_p[k+1]),
      .out_shift  (shift_p[k+1])
    );
  end

  // Payload registers are never reset, so the outputs are qualified by the last valid bit.
  assign out_valid_o = vld_p[SHW];
  assign result_o    = vld_p[SHW] ? data_p[SHW] : '0;
`ifdef VARIABLE_LOGICAL_RIGHTSHIFT_STICKY_EN
  assign sticky_o    = vld_p[SHW] & sticky_p[SHW];
`endif

endmodule

// File: tb/tb_variable_logical_rightshift_pipe.sv
// Scoreboard bench for variable_logical_rightshift_pipe; sticky checks follow
// VARIABLE_LOGICAL_RIGHTSHIFT_STICKY_EN.
module tb_variable_logical_rightshift_pipe;

  localparam int W  = 32;
  localparam int SW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  val = '0;
  logic [SW-1:0] sh = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  result;
`ifdef VARIABLE_LOGICAL_RIGHTSHIFT_STICKY_EN
  logic          sticky;
`endif

  always #5 clk = ~clk;

  variable_logical_rightshift_pipe #(.WIDTH(W)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .val_i       (val),
    .shift_n_i   (sh),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
`ifdef VARIABLE_LOGICAL_RIGHTSHIFT_STICKY_EN
    .sticky_o    (sticky),
`endif
    .result_o    (result)
  );

  typedef struct {
    logic [W-1:0] res;
    logic         stk;
  } exp_t;

  exp_t   q[$];
  int     total = 0;
  int     bad   = 0;
  logic   bub   = 1'b0;
  logic [15:0] vhist = '0;

  // Reference: treat the operand as an integer with a W-bit fraction below it;
  // the integer part is the result, any nonzero fraction bit is the sticky.
  function automatic exp_t model(input logic [W-1:0] v, input logic [SW-1:0] s);
    exp_t e;
    logic [2*W-1:0] wide;
    wide  = {v, {W{1'b0}}} >> s;
    e.res = wide[2*W-1:W];
    e.stk = |wide[W-1:0];
    return e;
  endfunction

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h at %0t", name, got, want, $time);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Input side: record every accepted operand's expected result.
  always @(negedge clk) begin
    if (!rst && in_valid && in_ready) q.push_back(model(val, sh));
  end

  // Output side: compare every retired result, and hold during stalls.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      check("in_ready_rule", in_ready, !out_valid || out_ready);
      if (out_valid) begin
        if (q.size() == 0) begin
          fail_now("spurious_result");
        end else if (out_ready) begin
          e = q.pop_front();
          check("result", result, e.res);
`ifdef VARIABLE_LOGICAL_RIGHTSHIFT_STICKY_EN
          check("sticky", sticky, e.stk);
`endif
        end else begin
          check("stall_hold", result, q[0].res);
          check("stall_in_ready", in_ready, 0);
        end
      end
    end
  end

  // Bubble pattern: out_valid equals the input fire pattern five cycles earlier.
  always @(negedge clk) begin
    if (bub) check("bubble_pattern", out_valid, vhist[SW-1]);
    vhist <= {vhist[14:0], (in_valid && in_ready && !rst)};
  end

  // Called at posedge+1; returns at posedge+1 after the operand is accepted.
  task automatic send(input logic [W-1:0] v, input logic [SW-1:0] s);
    int n;
    n = 0;
    in_valid = 1'b1;
    val = v;
    sh = s;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) fail_now("timeout_send");
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    while (q.size() != 0 && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (q.size() != 0) fail_now("timeout_drain");
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_result", result, 0);
`ifdef VARIABLE_LOGICAL_RIGHTSHIFT_STICKY_EN
    check("reset_sticky", sticky, 0);
`endif
    rst = 1'b0;
    #1;
    check("ready_after_reset", in_ready, 1);
    @(posedge clk);
    #1;

    // Latency: accepted at edge t, visible after edge t+4
    in_valid = 1'b1;
    val = 32'h8000_0000;
    sh = 5'd31;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int c = 1; c <= SW; c++) begin
      @(negedge clk);
      check("latency_valid", out_valid, (c == SW));
    end
    check("shift31_result", result, 32'h0000_0001);
    @(posedge clk);
    #1;
    send(32'hDEAD_BEEF, 5'd0);
`ifdef VARIABLE_LOGICAL_RIGHTSHIFT_STICKY_EN
    send(32'hFFFF_FFFF, 5'd4);
    send(32'h1234_5600, 5'd8);
    send(32'h0000_0000, 5'd17);
    send(32'h0000_0001, 5'd1);
`endif
    drain();

    // Back-to-back full-rate stream with no output gaps
    fork
      begin
        for (int i = 0; i < 32; i++) send(32'hFFFF_FFFF, i[SW-1:0]);
      end
      begin
        int m;
        m = 0;
        @(negedge clk);
        while (!out_valid && m < 50) begin
          m++;
          @(negedge clk);
        end
        for (int j = 0; j < 32; j++) begin
          check("no_gap", out_valid, 1);
          @(negedge clk);
        end
      end
    join
    drain();

    // Backpressure: three stalled cycles while operands keep arriving
    fork
      begin
        for (int i = 0; i < 8; i++) send($urandom, SW'($urandom_range(0, W-1)));
      end
      begin
        int m;
        m = 0;
        @(negedge clk);
        while (!out_valid && m < 50) begin
          m++;
          @(negedge clk);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("bp_in_ready", in_ready, 0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Bubbles: valid every other cycle
    bub = 1'b1;
    for (int i = 0; i < 24; i++) begin
      in_valid = (i % 2 == 0);
      val = $urandom;
      sh = SW'($urandom_range(0, W-1));
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    repeat (SW + 1) @(posedge clk);
    #1;
    bub = 1'b0;
    drain();

    // Reset mid-stream with results pending and one on the output
    for (int i = 0; i < 6; i++) send($urandom | 32'h1, 5'd0);
    check("pre_reset_valid", out_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_valid", out_valid, 0);
    check("async_reset_result", result, 0);
    q.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("post_reset_quiet", out_valid, 0);
    end
    @(posedge clk);
    #1;

    // Randomized traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      val       = $urandom;
      if ($urandom_range(0, 7) == 0) val = '0;
      sh        = SW'($urandom_range(0, W-1));
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    drain();

    n = q.size();
    check("scoreboard_empty", n, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
